// File: rtl/cmp_iter.sv
// rtl/cmp_iter.sv - multi-cycle slice-serial RISC-V branch comparator (EQ/NE/LT/GE/LTU/GEU)
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1_d,
    input  logic [WIDTH-1:0] rs2_d,
    input  logic [2:0]       cmp_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             b,
    output logic             busy
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx;
    logic             decided;
    logic             lt;

    logic [CHUNK-1:0] s1;
    logic [CHUNK-1:0] s2;
    logic             diff;
    logic             eq_n;
    logic             lt_n;
    logic             res;

    always_comb begin
        s1 = '0;
        s2 = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == i[IW-1:0]) begin
                s1 = opa[i*CHUNK +: CHUNK];
                s2 = opb[i*CHUNK +: CHUNK];
            end
        end
        // Flipping the sign bit of the top slice turns signed order into unsigned order
        if (idx == TOP_IDX && (op_q == OP_LT || op_q == OP_GE)) begin
            s1[CHUNK-1] = ~s1[CHUNK-1];
            s2[CHUNK-1] = ~s2[CHUNK-1];
        end
    end

    assign diff = !decided && (s1 != s2);
    assign eq_n = !(decided || diff);
    assign lt_n = diff ? (s1 < s2) : lt;

    always_comb begin
        res = 1'b0;
        case (op_q)
            OP_EQ:  res = eq_n;
            OP_NE:  res = !eq_n;
            OP_LT:  res = lt_n;
            OP_LTU: res = lt_n;
            OP_GE:  res = !lt_n;
            OP_GEU: res = !lt_n;
            default: res = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            opa     <= '0;
            opb     <= '0;
            op_q    <= '0;
            idx     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            b       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opa     <= rs1_d;
                        opb     <= rs2_d;
                        op_q    <= cmp_op;
                        idx     <= TOP_IDX;
                        decided <= 1'b0;
                        lt      <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (diff) begin
                        decided <= 1'b1;
                        lt      <= lt_n;
                        b       <= res;
                        state   <= S_DONE;
                    end else if (idx == '0) begin
                        decided <= 1'b0;
                        b       <= res;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

endmodule

// File: tb/tb_cmp_iter.sv
// tb/tb_cmp_iter.sv - self-checking bench for cmp_iter (CHUNK=8 and CHUNK=32 instances)
module tb_cmp_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] rs1_d = '0;
    logic [31:0] rs2_d = '0;
    logic [2:0]  cmp_op = '0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;

    logic in_ready0, out_valid0, b0, busy0;
    logic in_ready1, out_valid1, b1, busy1;
    logic in_ready, out_valid, bo, busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready0),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .cmp_op(cmp_op), .out_valid(out_valid0),
        .out_ready(out_ready), .b(b0), .busy(busy0)
    );

    cmp_iter #(.WIDTH(32), .CHUNK(32)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready1),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .cmp_op(cmp_op), .out_valid(out_valid1),
        .out_ready(out_ready), .b(b1), .busy(busy1)
    );

    assign in_ready  = sel ? in_ready1  : in_ready0;
    assign out_valid = sel ? out_valid1 : out_valid0;
    assign bo        = sel ? b1         : b0;
    assign busy      = sel ? busy1      : busy0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] c;
        logic        exp_b;
        int          exp_k;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic ref_b(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c);
        case (op)
            3'b000: return a == c;
            3'b001: return a != c;
            3'b010: return $signed(a) < $signed(c);
            3'b011: return $signed(a) >= $signed(c);
            3'b100: return a < c;
            3'b101: return a >= c;
            default: return 1'b0;
        endcase
    endfunction

    // Slices examined = distance from the top down to the first differing slice
    function automatic int ref_k(input logic [31:0] a, input logic [31:0] c, input int chunk);
        int n = 32 / chunk;
        logic [31:0] x = a ^ c;
        for (int i = n - 1; i >= 0; i--) begin
            if (((x >> (i * chunk)) & ((chunk == 32) ? 32'hFFFF_FFFF : ((32'd1 << chunk) - 1))) != 0)
                return n - i;
        end
        return n;
    endfunction

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] c, input logic exp_b, input int exp_k);
        int cyc = 0;
        @(negedge clk);
        in_valid = 1'b1; rs1_d = a; rs2_d = c; cmp_op = op; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, exp_k);
        check({name, " b"}, {31'd0, bo}, {31'd0, exp_b});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " back to idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] a, c, held_b;
        logic [2:0]  op;
        int          cyc;

        vecs[0]  = '{3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1, 4};
        vecs[1]  = '{3'b001, 32'h1234_5678, 32'h1234_5678, 1'b0, 4};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1};
        vecs[3]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1};
        vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1};
        vecs[5]  = '{3'b101, 32'h0000_0100, 32'h0000_00FF, 1'b1, 3};
        vecs[6]  = '{3'b100, 32'h0000_0100, 32'h0000_00FF, 1'b0, 3};
        vecs[7]  = '{3'b110, 32'h1234_5678, 32'h1234_5679, 1'b0, 4};
        vecs[8]  = '{3'b111, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4};
        vecs[9]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 1'b1, 4};
        vecs[10] = '{3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1};
        vecs[11] = '{3'b101, 32'h0000_0001, 32'h0000_0002, 1'b0, 4};

        #1;
        check("reset in_ready", {31'd0, in_ready0}, 32'd1);
        check("reset out_valid/b/busy", {29'd0, out_valid0, b0, busy0}, 32'd0);
        check("reset wide out_valid/b/busy", {28'd0, in_ready1, out_valid1, b1, busy1}, 32'd8);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].c, vecs[i].exp_b, vecs[i].exp_k);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            c = a;
            for (int s = 0; s < 4; s++)
                if ($urandom_range(0, 2) == 0) c[s*8 +: 8] = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            do_op($sformatf("rnd%0d op%0d", i, op), op, a, c, ref_b(op, a, c), ref_k(a, c, 8));
        end

        // Backpressure: result must hold while the consumer stalls and new requests are refused
        @(negedge clk);
        in_valid = 1'b1; rs1_d = 32'h0000_0005; rs2_d = 32'h0000_0007; cmp_op = 3'b100;
        @(posedge clk); #1;
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("bp latency", cyc, 4);
        held_b = {31'd0, bo};
        check("bp b", held_b, 32'd1);
        rs1_d = 32'h0; rs2_d = 32'h0; cmp_op = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold %0d", i), {28'd0, out_valid, bo, busy, in_ready}, 32'b1110);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // Asynchronous reset while walking slices
        @(negedge clk);
        in_valid = 1'b1; rs1_d = 32'hAAAA_5555; rs2_d = 32'hAAAA_5555; cmp_op = 3'b000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst mid-run", {29'd0, in_ready, out_valid, busy}, 32'b100);
        @(negedge clk);
        rst = 1'b0;
        do_op("after rst", 3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1);

        sel = 1'b1;
        do_op("wide lt", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1);
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            c = (i % 2 == 0) ? a : 32'($urandom);
            op = 3'(i % 8);
            do_op($sformatf("wide%0d op%0d", i, op), op, a, c, ref_b(op, a, c), 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
